accum_read_ctrl: RTL and testbench

ACCUM_READ_CTRL -- requirements
Module: accum_read_ctrl

---
 rtl/accum_read_ctrl_if.sv | 46 ++++
 rtl/accum_read_ctrl.sv | 115 +++++++++++
 tb/tb_accum_read_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_read_ctrl_if.sv
// ============================================================================
// Module   : accum_read_ctrl_if
// Brief    : Bus bundle between the accumulating read controller and its
//            address counter / synchronous memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface accum_read_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 12
);
    logic              start;
    logic [3:0]        address_counter;
    logic [DATA_W-1:0] mem_data;
    logic              address_gen_enable;
    logic              counter_reset;
    logic [SUM_W-1:0]  sum;
    logic              busy;
    logic              done;

    // Master is the surrounding system (requester, counter, memory).
    modport master (
        output start,
        output address_counter,
        output mem_data,
        input  address_gen_enable,
        input  counter_reset,
        input  sum,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  address_counter,
        input  mem_data,
        output address_gen_enable,
        output counter_reset,
        output sum,
        output busy,
        output done
    );
endinterface

`default_nettype wire

// File: rtl/accum_read_ctrl.sv
// ============================================================================
// Module   : accum_read_ctrl
// Brief    : Sweeps an external address counter 0..LAST_ADDR and sums the
//            one-cycle-latency memory read data into an accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_read_ctrl #(
    parameter int         DATA_W    = 8,
    parameter int         SUM_W     = 12,
    parameter logic [3:0] LAST_ADDR = 4'd10
) (
    input  wire logic           clk,
    input  wire logic           reset,
    accum_read_ctrl_if.slave    bus
);

    localparam logic [3:0] C_PARK_ADDR = 4'hF;

    if (SUM_W < DATA_W + 4) begin : g_sum_w_check
        $error("accum_read_ctrl: SUM_W must be at least DATA_W+4");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Async assert, sync release: the first edge after release sees IDLE.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    state_t           r_state;
    state_t           w_state_next;
    logic             r_rd_valid;
    logic             w_rd_valid_next;
    logic [SUM_W-1:0] r_sum;
    logic [SUM_W-1:0] w_sum_next;
    logic [SUM_W-1:0] w_mem_ext;

    assign w_mem_ext = {{(SUM_W-DATA_W){1'b0}}, bus.mem_data};

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            r_rd_valid <= 1'b0;
            r_sum      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rd_valid <= w_rd_valid_next;
            r_sum      <= w_sum_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_rd_valid_next = 1'b0;
        w_sum_next      = r_sum;

        // rd_valid marks the cycle whose mem_data belongs to a real address.
        if (r_rd_valid) begin
            w_sum_next = r_sum + w_mem_ext;
        end

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_sum_next   = '0;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                w_rd_valid_next = (bus.address_counter != C_PARK_ADDR);
                if (bus.address_counter == LAST_ADDR) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.address_gen_enable = (r_state == S_RUN) && (bus.address_counter != LAST_ADDR);
    assign bus.counter_reset      = (r_state == S_CLEAR);
    assign bus.busy               = (r_state != S_IDLE);
    assign bus.done               = (r_state == S_DONE);
    assign bus.sum                = r_sum;

endmodule

`default_nettype wire

// File: tb/tb_accum_read_ctrl.sv
// ============================================================================
// Module   : tb_accum_read_ctrl
// Brief    : Self-checking bench with counter and 1-cycle memory models.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accum_read_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    accum_read_ctrl_if #(.DATA_W(8), .SUM_W(12)) bus_if ();

    accum_read_ctrl #(
        .DATA_W    (8),
        .SUM_W     (12),
        .LAST_ADDR (4'd10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // Upstream counter: clear loads F, counts while enabled, holds at 10.
    logic [3:0] cnt = 4'hF;
    always @(posedge clk) begin
        if (bus_if.counter_reset) begin
            cnt <= 4'hF;
        end else if (bus_if.address_gen_enable && cnt != 4'd10) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Optional one-cycle stray address replacing address glitch_k.
    logic       glitch_en = 1'b0;
    logic [3:0] glitch_k  = 4'd0;
    logic [3:0] stray     = 4'd12;
    assign bus_if.address_counter = (glitch_en && cnt == glitch_k) ? stray : cnt;

    logic [7:0] mem [16];
    always @(posedge clk) begin
        bus_if.mem_data <= mem[bus_if.address_counter];
    end

    int done_cnt = 0;
    int acc_cnt  = 0;
    always @(negedge clk) begin
        if (bus_if.done) done_cnt <= done_cnt + 1;
        if (dut.r_rd_valid) acc_cnt <= acc_cnt + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < 16; i++) begin
            case (pat)
                0:       mem[i] = 8'hFF;
                1:       mem[i] = 8'(i);
                2:       mem[i] = 8'h01;
                3:       mem[i] = 8'h00;
                4:       mem[i] = 8'h80;
                5:       mem[i] = (i % 2 == 1) ? 8'hFF : 8'h00;
                default: mem[i] = 8'($urandom);
            endcase
        end
    endtask

    // Reference: sum of the eleven reads 0..10, one possibly replaced by the stray.
    function automatic logic [11:0] model_sum(input bit g, input int k, input logic [3:0] s);
        logic [11:0] t;
        logic [3:0]  a;
        t = '0;
        for (int i = 0; i <= 10; i++) begin
            a = (g && i == k) ? s : 4'(i);
            t = t + {4'b0, mem[a]};
        end
        return t;
    endfunction

    task automatic do_sweep(input string tag, input logic [11:0] exp_sum, input bit rand_start);
        int n;
        int d0;
        int a0;
        d0 = done_cnt;
        a0 = acc_cnt;
        @(negedge clk);
        bus_if.start = 1'b1;
        @(posedge clk);
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) check({tag, "_counter_reset"}, bus_if.counter_reset, 1);
            if (n == 1) check({tag, "_sum_cleared"}, bus_if.sum, 0);
            if (bus_if.done) begin
                bus_if.start = 1'b0;
                break;
            end
            bus_if.start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        bus_if.start = 1'b0;
        check({tag, "_latency"}, n, 14);
        check({tag, "_sum"}, bus_if.sum, exp_sum);
        @(negedge clk);
        check({tag, "_idle_busy"}, bus_if.busy, 0);
        @(negedge clk);
        check({tag, "_sum_hold"}, bus_if.sum, exp_sum);
        check({tag, "_addr_parked"}, cnt, 10);
        check({tag, "_enable_off"}, bus_if.address_gen_enable, 0);
        check({tag, "_one_done"}, done_cnt - d0, 1);
        check({tag, "_acc_edges"}, acc_cnt - a0, 11);
    endtask

    typedef struct {
        int          pat;
        logic [11:0] exp_sum;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int first;
        int second;
        int d0;
        bit g;
        int k;
        logic [3:0] s;

        vecs[0] = '{0, 12'hAF5};
        vecs[1] = '{1, 12'h037};
        vecs[2] = '{2, 12'h00B};
        vecs[3] = '{3, 12'h000};
        vecs[4] = '{4, 12'h580};
        vecs[5] = '{5, 12'h4FB};

        bus_if.start = 1'b0;
        fill(3);
        repeat (3) @(negedge clk);
        check("rst_sum", bus_if.sum, 0);
        check("rst_busy", bus_if.busy, 0);
        check("rst_done", bus_if.done, 0);
        check("rst_counter_reset", bus_if.counter_reset, 0);
        check("rst_enable", bus_if.address_gen_enable, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            fill(vecs[i].pat);
            do_sweep($sformatf("vec%0d", i), vecs[i].exp_sum, 1'b0);
        end

        // Back-to-back: result 55 must not carry into the next sweep.
        fill(1);
        do_sweep("first55", 12'h037, 1'b0);
        fill(0);
        do_sweep("second", 12'hAF5, 1'b0);

        // Stray address 12 read in place of address 3.
        fill(1);
        glitch_en = 1'b1;
        glitch_k  = 4'd3;
        stray     = 4'd12;
        do_sweep("stray", 12'h040, 1'b0);
        glitch_en = 1'b0;

        for (int r = 0; r < 12; r++) begin
            fill(99);
            g = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 9);
            s = 4'($urandom_range(11, 14));
            glitch_en = g;
            glitch_k  = 4'(k);
            stray     = s;
            do_sweep($sformatf("rand%0d", r), model_sum(g, k, s), 1'b1);
        end
        glitch_en = 1'b0;

        // start held high: dones at 14 and 30, IDLE visited in between.
        fill(0);
        d0 = done_cnt;
        first = -1;
        second = -1;
        @(negedge clk);
        bus_if.start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus_if.done) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
            if (n == 15) check("held_idle_gap", bus_if.busy, 0);
        end
        bus_if.start = 1'b0;
        check("held_first_done", first, 14);
        check("held_second_done", second, 30);
        repeat (20) @(negedge clk);
        check("held_done_count", done_cnt - d0, 3);
        check("held_sum", bus_if.sum, 12'hAF5);

        // Abort mid-sweep with reset while address 5 is presented.
        fill(0);
        d0 = done_cnt;
        @(negedge clk);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (bus_if.address_counter == 4'd5) break;
            @(negedge clk);
        end
        check("abort_addr5_reached", bus_if.address_counter, 5);
        #2 reset = 1'b0;
        #1;
        check("abort_sum", bus_if.sum, 0);
        check("abort_busy", bus_if.busy, 0);
        check("abort_done", bus_if.done, 0);
        check("abort_counter_reset", bus_if.counter_reset, 0);
        check("abort_enable", bus_if.address_gen_enable, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        fill(2);
        do_sweep("after_abort", 12'h00B, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
